conv_accumulator: RTL and testbench
===================================

Name: conv_accumulator

Overview:
Consumer end of the multiplier product stream (product/p_valid) in the convolution datapath. Sums TAPS consecutive valid signed products into one kernel-window result. Applies an arithmetic right shift for normalisation and clamps to an 8-bit unsigned output pixel. Emits that pixel with a single-cycle valid strobe. Sits directly after the per-tap multiplier and before the output pixel writer.

Parameters:
TAPS, 9, products per kernel window (3x3); legal range 2..16
PROD_W, 14, signed product width from multiplier
ACC_W, 18, signed accumulator width; must hold TAPS * (-2040) without overflow
SHIFT, 0, arithmetic right shift applied to window sum before clamp (floor, no rounding)
PIX_W, 8, unsigned output pixel width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous abort of the current partial window
p_valid  in  1  product qualifier
product  in  PROD_W signed  product from multiplier
pix_out  out  PIX_W  clamped window result
pix_valid  out  1  one-cycle strobe, pix_out/acc_raw/sat_* valid
acc_raw  out  ACC_W signed  unshifted, unclamped window sum
sat_hi  out  1  result clamped to 255 (qualified by pix_valid)
sat_lo  out  1  result clamped to 0 (qualified by pix_valid)
tap_cnt  out  clog2(TAPS)  products accepted so far in the current window

Behaviour:
- Reset (rst_n low, async): acc=0, tap_cnt=0, pix_out=0, pix_valid=0, acc_raw=0, sat_hi=0, sat_lo=0. Reset mid-window discards the partial sum.
- Two states:
  - ACCUM: tap_cnt < TAPS-1.
  - LAST: tap_cnt == TAPS-1.
  - Encoded by tap_cnt alone; no separate FSM register.
- Product sign-extended PROD_W->ACC_W before every add.
- ACCUM with p_valid=1: acc <= acc + product; tap_cnt++.
- LAST with p_valid=1 (window completes):
  - sum = acc + product.
  - Next cycle: pix_valid=1, acc_raw=sum, pix_out=clamp(sum >>> SHIFT, 0, 255), sat_hi=(shifted>255), sat_lo=(shifted<0).
  - Same edge: acc<=0, tap_cnt<=0.
  - Latency: 1 cycle from the final product to pix_valid.
- p_valid=0: acc and tap_cnt hold. Gaps between taps are legal.
- pix_valid is high for exactly one cycle per completed window.
- pix_out, acc_raw and sat_* hold their last values when pix_valid=0.
- Back-to-back windows: a p_valid in the cycle after completion is tap 0 of the next window, with no bubble. Minimum spacing of pix_valid pulses is TAPS cycles.
- clear=1: acc<=0, tap_cnt<=0 next edge.
  - Clear wins over a simultaneous p_valid; that product is discarded.
  - If clear coincides with the completing product, no pix_valid is generated.
  - clear does not cancel a pix_valid already registered.
- No overflow detection on acc. ACC_W sizing is a parameter obligation, checked by a static assertion (elaboration-time check).

Decomposition:
- Package conv_pkg: PIX_W=8, KERN_W=4, PROD_W=14 constants, and a function acc_width(taps) giving the minimum safe ACC_W.
- One combinational sub-module pixel_clamp (ACC_W, SHIFT, PIX_W params):
  - Inputs: sum.
  - Outputs: pix, sat_hi, sat_lo.
  - Does the arithmetic shift plus clamp; reused later by other output paths.

Test Plan:
- Nine contiguous p_valid with product=10 -> one cycle after the 9th: pix_valid=1, acc_raw=90, pix_out=90, sat_hi=0, sat_lo=0; tap_cnt returns to 0.
- Nine products of 100 -> acc_raw=900, pix_out=255, sat_hi=1. Then nine products of -100 -> acc_raw=-900, pix_out=0, sat_lo=1.
- Nine products of 1 with random p_valid gaps (1..3 idle cycles), then a second window of 2s with no gap -> pix_out 9 then 18. The second pix_valid comes exactly 9 cycles after the first.
- Five products of 50, then clear together with a sixth product, then nine products of 1 -> single pix_valid with acc_raw=9. No pulse for the aborted window.
- rst_n pulsed low asynchronously (mid-cycle) after four products of 7 -> all outputs 0 immediately. The next full window of nine 3s yields pix_out=27.
- Instance with SHIFT=3: nine products of 50 -> acc_raw=450, pix_out=56. Nine products of -1 -> (-9>>>3)=-2, pix_out=0, sat_lo=1.

Source files
------------

// File: rtl/conv_pkg.sv
//------------------------------------------------------------------------------
// conv_pkg: shared widths, tap phase type and accumulator sizing helper.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package conv_pkg;

  localparam int PIX_W  = 8;
  localparam int KERN_W = 4;
  localparam int PROD_W = 14;

  // Most negative product: largest pixel times most negative kernel weight.
  localparam int PROD_MAG = ((2 ** PIX_W) - 1) * (2 ** (KERN_W - 1));

  typedef enum logic {
    PH_ACCUM = 1'b0,
    PH_LAST  = 1'b1
  } phase_e;

  // Smallest signed width that holds taps * (-PROD_MAG) without overflow.
  function automatic int acc_width(input int taps);
    int need;
    int w;
    need = taps * PROD_MAG;
    w    = 32;
    for (int i = 31; i >= 1; i--) begin
      if ((1 << (i - 1)) >= need) w = i;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_clamp.sv
//------------------------------------------------------------------------------
// pixel_clamp: arithmetic right shift of a signed sum, clamped to unsigned pixel.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pixel_clamp #(
  parameter int ACC_W = 18,
  parameter int SHIFT = 0,
  parameter int PIX_W = 8
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic        [PIX_W-1:0] pix,
  output logic                    sat_hi,
  output logic                    sat_lo
);

  localparam logic signed [ACC_W-1:0] C_PIX_MAX = ACC_W'((1 << PIX_W) - 1);

  logic signed [ACC_W-1:0] shifted_w;

  always_comb begin
    shifted_w = sum >>> SHIFT;
    sat_hi    = (shifted_w > C_PIX_MAX);
    sat_lo    = shifted_w[ACC_W-1];
    if (sat_hi) begin
      pix = {PIX_W{1'b1}};
    end else if (sat_lo) begin
      pix = '0;
    end else begin
      pix = shifted_w[PIX_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_accumulator.sv
//------------------------------------------------------------------------------
// conv_accumulator: sums TAPS signed products per window, emits a clamped pixel.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module conv_accumulator #(
  parameter int TAPS   = 9,
  parameter int PROD_W = 14,
  parameter int ACC_W  = 18,
  parameter int SHIFT  = 0,
  parameter int PIX_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        p_valid,
  input  logic signed [PROD_W-1:0]    product,
  output logic        [PIX_W-1:0]     pix_out,
  output logic                        pix_valid,
  output logic signed [ACC_W-1:0]     acc_raw,
  output logic                        sat_hi,
  output logic                        sat_lo,
  output logic [$clog2(TAPS)-1:0]     tap_cnt
);

  import conv_pkg::*;

  localparam int CNT_W = $clog2(TAPS);
  localparam logic [CNT_W-1:0] C_LAST_TAP = CNT_W'(TAPS - 1);

  if ((TAPS < 2) || (TAPS > 16)) begin : g_bad_taps
    $error("conv_accumulator: TAPS out of range 2..16");
  end
  if (ACC_W < acc_width(TAPS)) begin : g_bad_acc_w
    $error("conv_accumulator: ACC_W too narrow for TAPS worst-case sum");
  end

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        tap_cnt_q, tap_cnt_d;
  logic [PIX_W-1:0]        pix_out_q, pix_out_d;
  logic                    pix_valid_q, pix_valid_d;
  logic signed [ACC_W-1:0] acc_raw_q, acc_raw_d;
  logic                    sat_hi_q, sat_hi_d;
  logic                    sat_lo_q, sat_lo_d;

  logic signed [ACC_W-1:0] prod_ext_w;
  logic signed [ACC_W-1:0] sum_w;
  logic [PIX_W-1:0]        clamp_pix_w;
  logic                    clamp_hi_w;
  logic                    clamp_lo_w;
  phase_e                  phase_w;

  assign prod_ext_w = {{(ACC_W - PROD_W){product[PROD_W-1]}}, product};
  assign sum_w      = acc_q + prod_ext_w;
  assign phase_w    = (tap_cnt_q == C_LAST_TAP) ? PH_LAST : PH_ACCUM;

  pixel_clamp #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .PIX_W (PIX_W)
  ) u_clamp (
    .sum    (sum_w),
    .pix    (clamp_pix_w),
    .sat_hi (clamp_hi_w),
    .sat_lo (clamp_lo_w)
  );

  always_comb begin
    acc_d       = acc_q;
    tap_cnt_d   = tap_cnt_q;
    pix_out_d   = pix_out_q;
    pix_valid_d = 1'b0;
    acc_raw_d   = acc_raw_q;
    sat_hi_d    = sat_hi_q;
    sat_lo_d    = sat_lo_q;
    // Clear discards any product arriving with it, including a completing one.
    if (clear) begin
      acc_d     = '0;
      tap_cnt_d = '0;
    end else if (p_valid) begin
      if (phase_w == PH_LAST) begin
        acc_d       = '0;
        tap_cnt_d   = '0;
        pix_valid_d = 1'b1;
        acc_raw_d   = sum_w;
        pix_out_d   = clamp_pix_w;
        sat_hi_d    = clamp_hi_w;
        sat_lo_d    = clamp_lo_w;
      end else begin
        acc_d     = sum_w;
        tap_cnt_d = tap_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      tap_cnt_q   <= '0;
      pix_out_q   <= '0;
      pix_valid_q <= 1'b0;
      acc_raw_q   <= '0;
      sat_hi_q    <= 1'b0;
      sat_lo_q    <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      tap_cnt_q   <= tap_cnt_d;
      pix_out_q   <= pix_out_d;
      pix_valid_q <= pix_valid_d;
      acc_raw_q   <= acc_raw_d;
      sat_hi_q    <= sat_hi_d;
      sat_lo_q    <= sat_lo_d;
    end
  end

  assign pix_out   = pix_out_q;
  assign pix_valid = pix_valid_q;
  assign acc_raw   = acc_raw_q;
  assign sat_hi    = sat_hi_q;
  assign sat_lo    = sat_lo_q;
  assign tap_cnt   = tap_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_accumulator.sv
//------------------------------------------------------------------------------
// tb_conv_accumulator: two instances (SHIFT=0 and SHIFT=3) checked against a
// window-queue reference model, plus fixed vectors and corner sequences.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_conv_accumulator;

  localparam int TAPS   = 9;
  localparam int PROD_W = 14;
  localparam int ACC_W  = 18;
  localparam int PIX_W  = 8;
  localparam int CW     = $clog2(TAPS);

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     clear = 1'b0;
  logic                     p_valid = 1'b0;
  logic signed [PROD_W-1:0] product = '0;

  logic [PIX_W-1:0]        o0_pix, o3_pix;
  logic                    o0_valid, o3_valid;
  logic signed [ACC_W-1:0] o0_raw, o3_raw;
  logic                    o0_hi, o3_hi, o0_lo, o3_lo;
  logic [CW-1:0]           o0_cnt, o3_cnt;

  conv_accumulator #(.TAPS(TAPS), .PROD_W(PROD_W), .ACC_W(ACC_W), .SHIFT(0), .PIX_W(PIX_W)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .p_valid(p_valid), .product(product),
    .pix_out(o0_pix), .pix_valid(o0_valid), .acc_raw(o0_raw),
    .sat_hi(o0_hi), .sat_lo(o0_lo), .tap_cnt(o0_cnt)
  );

  conv_accumulator #(.TAPS(TAPS), .PROD_W(PROD_W), .ACC_W(ACC_W), .SHIFT(3), .PIX_W(PIX_W)) dut_s3 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .p_valid(p_valid), .product(product),
    .pix_out(o3_pix), .pix_valid(o3_valid), .acc_raw(o3_raw),
    .sat_hi(o3_hi), .sat_lo(o3_lo), .tap_cnt(o3_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int win[$];
  int pulse_at[$];

  bit e_valid;
  int e_raw;
  int e_pix[2];
  bit e_hi[2];
  bit e_lo[2];

  typedef struct {
    int prod;
    int raw;
    int pix0; bit hi0; bit lo0;
    int pix3; bit hi3; bit lo3;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int floor_shift(input int s, input int sh);
    int d;
    d = 1 << sh;
    if (s >= 0) return s / d;
    return -(((-s) + d - 1) / d);
  endfunction

  task automatic model_reset();
    win.delete();
    e_valid = 1'b0;
    e_raw   = 0;
    for (int k = 0; k < 2; k++) begin
      e_pix[k] = 0; e_hi[k] = 1'b0; e_lo[k] = 1'b0;
    end
  endtask

  // A window is the list of accepted products; it completes once it holds TAPS.
  task automatic model_step(input bit pv, input int prod, input bit clr);
    int s;
    int sh;
    e_valid = 1'b0;
    if (clr) begin
      win.delete();
    end else if (pv) begin
      win.push_back(prod);
      if (win.size() == TAPS) begin
        s = 0;
        foreach (win[i]) s += win[i];
        win.delete();
        e_valid = 1'b1;
        e_raw   = s;
        for (int k = 0; k < 2; k++) begin
          sh       = floor_shift(s, (k == 0) ? 0 : 3);
          e_hi[k]  = (sh > 255);
          e_lo[k]  = (sh < 0);
          e_pix[k] = e_hi[k] ? 255 : (e_lo[k] ? 0 : sh);
        end
      end
    end
  endtask

  task automatic check_all();
    chk("valid_s0", o0_valid, e_valid);
    chk("valid_s3", o3_valid, e_valid);
    chk("tap_cnt_s0", o0_cnt, win.size());
    chk("tap_cnt_s3", o3_cnt, win.size());
    chk("acc_raw_s0", o0_raw, e_raw);
    chk("acc_raw_s3", o3_raw, e_raw);
    chk("pix_s0", o0_pix, e_pix[0]);
    chk("pix_s3", o3_pix, e_pix[1]);
    chk("sat_hi_s0", o0_hi, e_hi[0]);
    chk("sat_hi_s3", o3_hi, e_hi[1]);
    chk("sat_lo_s0", o0_lo, e_lo[0]);
    chk("sat_lo_s3", o3_lo, e_lo[1]);
  endtask

  task automatic cycle(input bit pv, input int prod, input bit clr);
    p_valid = pv;
    product = prod[PROD_W-1:0];
    clear   = clr;
    @(posedge clk);
    model_step(pv, prod, clr);
    cyc++;
    #1;
    check_all();
    if (o0_valid === 1'b1) pulse_at.push_back(cyc);
  endtask

  initial begin
    tbl[0] = '{prod:   10, raw:   90, pix0:  90, hi0: 0, lo0: 0, pix3:  11, hi3: 0, lo3: 0};
    tbl[1] = '{prod:  100, raw:  900, pix0: 255, hi0: 1, lo0: 0, pix3: 112, hi3: 0, lo3: 0};
    tbl[2] = '{prod: -100, raw: -900, pix0:   0, hi0: 0, lo0: 1, pix3:   0, hi3: 0, lo3: 1};
    tbl[3] = '{prod:   50, raw:  450, pix0: 255, hi0: 1, lo0: 0, pix3:  56, hi3: 0, lo3: 0};
    tbl[4] = '{prod:   -1, raw:   -9, pix0:   0, hi0: 0, lo0: 1, pix3:   0, hi3: 0, lo3: 1};
    tbl[5] = '{prod: 1785, raw: 16065, pix0: 255, hi0: 1, lo0: 0, pix3: 255, hi3: 1, lo3: 0};

    // Reset state
    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Constant-product windows from the vector table
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < TAPS; j++) cycle(1'b1, tbl[i].prod, 1'b0);
      chk("tbl_valid", o0_valid, 1);
      chk("tbl_raw", o0_raw, tbl[i].raw);
      chk("tbl_pix0", o0_pix, tbl[i].pix0);
      chk("tbl_hi0", o0_hi, tbl[i].hi0);
      chk("tbl_lo0", o0_lo, tbl[i].lo0);
      chk("tbl_pix3", o3_pix, tbl[i].pix3);
      chk("tbl_hi3", o3_hi, tbl[i].hi3);
      chk("tbl_lo3", o3_lo, tbl[i].lo3);
      chk("tbl_cnt", o0_cnt, 0);
      cycle(1'b0, 0, 1'b0);
      chk("tbl_hold_pix0", o0_pix, tbl[i].pix0);
    end

    // Gapped window of 1s, then an immediate window of 2s
    pulse_at.delete();
    for (int j = 0; j < TAPS; j++) begin
      cycle(1'b1, 1, 1'b0);
      if (j < TAPS - 1) repeat ($urandom_range(1, 3)) cycle(1'b0, 0, 1'b0);
    end
    chk("gap_pix", o0_pix, 9);
    for (int j = 0; j < TAPS; j++) cycle(1'b1, 2, 1'b0);
    chk("b2b_pix", o0_pix, 18);
    chk("pulse_count", pulse_at.size(), 2);
    if (pulse_at.size() == 2) chk("pulse_spacing", pulse_at[1] - pulse_at[0], TAPS);
    cycle(1'b0, 0, 1'b0);

    // Clear together with a product aborts the partial window
    pulse_at.delete();
    for (int j = 0; j < 5; j++) cycle(1'b1, 50, 1'b0);
    cycle(1'b1, 50, 1'b1);
    chk("clear_cnt", o0_cnt, 0);
    for (int j = 0; j < TAPS; j++) cycle(1'b1, 1, 1'b0);
    repeat (2) cycle(1'b0, 0, 1'b0);
    chk("clear_pulses", pulse_at.size(), 1);
    chk("clear_raw", o0_raw, 9);

    // Clear coinciding with the completing product yields no pulse
    pulse_at.delete();
    for (int j = 0; j < TAPS - 1; j++) cycle(1'b1, 4, 1'b0);
    cycle(1'b1, 4, 1'b1);
    cycle(1'b0, 0, 1'b0);
    chk("clear_last_pulses", pulse_at.size(), 0);

    // Asynchronous reset mid-window
    for (int j = 0; j < 4; j++) cycle(1'b1, 7, 1'b0);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_pix", o0_pix, 0);
    chk("rst_raw", o0_raw, 0);
    #3 rst_n = 1'b1;
    for (int j = 0; j < TAPS; j++) cycle(1'b1, 3, 1'b0);
    chk("post_rst_pix", o0_pix, 27);

    // Random traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 9) < 7, int'($urandom_range(0, 3825)) - 2040,
            $urandom_range(0, 31) == 0);
    end
    cycle(1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
